// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Single-port data memory that behaves like a slow processor-side memory.
// A request is accepted in IDLE, held for a fixed LATENCY, then answered with
// a one-cycle ready pulse carrying read data or a fault flag.
//
// Parameters
//   DEPTH    number of 32-bit words stored
//   LATENCY  edges from acceptance to the edge that raises ready (1..15)
//
// Ports
//   clk     in   1   rising-edge clock
//   reset   in   1   asynchronous, active-high reset
//   req     in   1   access request, sampled only in IDLE
//   we      in   1   1 = write, 0 = read; sampled with req
//   addr    in   32  byte address; word index = addr[31:2]
//   wdata   in   32  store data; sampled with req
//   ready   out  1   one-cycle response pulse
//   rdata   out  32  read data, valid while ready = 1, otherwise 0
//   err     out  1   access fault, valid while ready = 1, otherwise 0
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  // Index width; kept at least 1 so a single-word memory still elaborates.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_ready;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [DEPTH];

  logic          w_fault;
  logic          w_done;
  logic          w_mem_we;
  logic [AW-1:0] w_idx;

  // Fault on a misaligned address or a word index past the end of the array.
  // The index is widened to 32 bits so the range compare is not truncated.
  assign w_fault  = (r_addr[1:0] != 2'b00) ||
                    ({2'b00, r_addr[31:2]} >= 32'(DEPTH));
  assign w_idx    = r_addr[AW+1:2];

  // Last BUSY cycle: the coming edge moves to RESP and commits the access.
  assign w_done   = (r_state == BUSY) && (r_cnt == 4'd0);

  // Reset forces IDLE asynchronously, so an access interrupted in BUSY can
  // never raise this strobe and its write is dropped.
  assign w_mem_we = w_done && r_we && !w_fault;

  // NOTE: the storage array has no reset branch; contents are undefined until
  // written and must survive a reset, and leaving it out lets it map to RAM.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples values from before the edge, independent of order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_ready <= 1'b0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b0;
          r_rdata <= 32'd0;
          r_err   <= 1'b0;
          if (req) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_cnt   <= 4'(LATENCY - 1);
            r_state <= BUSY;
          end
        end

        BUSY: begin
          if (r_cnt == 4'd0) begin
            r_state <= RESP;
            r_ready <= 1'b1;
            r_err   <= w_fault;
            // Only a clean read returns data; writes and faults return 0.
            if (!w_fault && !r_we) begin
              r_rdata <= r_mem[w_idx];
            end else begin
              r_rdata <= 32'd0;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        RESP: begin
          r_ready <= 1'b0;
          r_rdata <= 32'd0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_ready <= 1'b0;
          r_rdata <= 32'd0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign rdata = r_rdata;
  assign err   = r_err;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words stored.
REQ-002 Parameter LATENCY, default 2: cycles from request acceptance to response; legal range 1..15.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  1  processor access request, sampled only in IDLE.
REQ-007 we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 addr  input  32  byte address; word index = addr[31:2].
REQ-009 wdata  input  32  store data; sampled with req.
REQ-010 ready  output  1  one-cycle pulse; response valid.
REQ-011 rdata  output  32  read data; valid while ready=1.
REQ-012 err  output  1  access fault flag; valid while ready=1.

Function
REQ-013 FSM states SHALL be IDLE, BUSY and RESP.
REQ-014 IDLE with req=1 at a rising edge (edge E0): capture we, addr, wdata; go to BUSY; load the wait counter with LATENCY-1.
REQ-015 IDLE with req=0: remain in IDLE; all outputs 0.
REQ-016 BUSY: at each edge, if the counter is 0, go to RESP; otherwise decrement the counter.
REQ-017 ready SHALL be 1 exactly in the cycle following edge E0+LATENCY (RESP state) and 0 in every other cycle.
REQ-018 RESP SHALL always return to IDLE on the next edge.
REQ-019 req SHALL be ignored in BUSY and RESP; captured request fields SHALL NOT change until the next acceptance.
REQ-020 Back-to-back accesses: the earliest next acceptance is the edge after the RESP cycle, so the minimum request spacing is LATENCY+2 cycles.
REQ-021 A fault SHALL exist when captured addr[1:0] != 0 or captured addr[31:2] >= DEPTH.
REQ-022 Write without fault: the memory word SHALL be updated at the edge entering RESP; rdata=0 and err=0 in RESP.
REQ-023 Read without fault: rdata SHALL be registered at the edge entering RESP with the word's current contents; err=0.
REQ-024 Faulted access: no memory update; rdata=0 and err=1 in RESP.
REQ-025 A read accepted after a write response to the same address SHALL return the written data.
REQ-026 rdata and err SHALL be 0 whenever ready=0.
REQ-027 Memory contents SHALL be undefined until written; no initialization is required.

Reset
REQ-028 Assertion of reset SHALL immediately force IDLE, counter=0, ready=0, rdata=0 and err=0, regardless of clk.
REQ-029 Reset during BUSY SHALL discard the pending access; a pending write SHALL NOT reach memory.
REQ-030 Reset SHALL NOT alter memory contents.
REQ-031 The first acceptance SHALL be the first rising edge with reset=0 and req=1.

Verification
REQ-032 Write then read, LATENCY=2: write addr=0x10, wdata=0xDEADBEEF at E0 -> ready=1 after E2 with err=0; then read addr=0x10 -> ready after 2 more edges with rdata=0xDEADBEEF, err=0.
REQ-033 Misaligned access: read addr=0x12 -> ready after LATENCY edges, err=1, rdata=0; a following read of 0x10 still returns the prior value.
REQ-034 Out-of-range write: DEPTH=64, write addr=0x100 with wdata=0x1 -> err=1; a subsequent read of 0x0 is unchanged.
REQ-035 req held high continuously for 20 cycles with LATENCY=1 -> ready pulses every 3 cycles, never on consecutive cycles.
REQ-036 Reset mid-access: write addr=0x4, wdata=0x55 and assert reset in BUSY -> all outputs 0 immediately; after release, read 0x4 returns the pre-reset value, not 0x55.
REQ-037 Latency sweep for LATENCY in {1, 2, 7, 15}: ready SHALL appear exactly LATENCY edges after acceptance.
